// File: rtl/gl_commit_ctrl_pkg.sv
// Shared types for the graduation-list commit slice.
//   gl_index_t     : index into the graduation list
//   exception_t    : oldest pending exception reported by the GL
//   commit_state_t : commit sequencer states
//   popcount2      : number of retire bits set in a 2-bit read_head vector
package gl_commit_ctrl_pkg;

    localparam int unsigned GL_IDX_W = 5;
    localparam int unsigned XLEN     = 64;

    typedef logic [GL_IDX_W-1:0] gl_index_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] origin;
    } exception_t;

    typedef enum logic [1:0] {
        IDLE,
        CSR_WAIT,
        FENCE_DRAIN
    } commit_state_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/gl_retire_select.sv
// Combinational retire eligibility for the two oldest GL slots on the
// plain (non-trap, non-serialising) commit path.
//   commit_valid_i     : slot valid bits
//   commit_ex_i        : slot carries an exception
//   commit_is_store_i  : slot is a store-class instruction
//   commit_is_csr_i    : slot is a CSR access
//   commit_is_fence_i  : slot is a FENCE/FENCE.I
//   store_ready_i      : store buffer accepts one store this cycle
//   slot0_retire_o     : slot0 may retire
//   slot1_retire_o     : slot1 may retire alongside slot0
module gl_retire_select
    import gl_commit_ctrl_pkg::*;
(
    input  logic [1:0] commit_valid_i,
    input  logic [1:0] commit_ex_i,
    input  logic [1:0] commit_is_store_i,
    input  logic [1:0] commit_is_csr_i,
    input  logic [1:0] commit_is_fence_i,
    input  logic       store_ready_i,
    output logic       slot0_retire_o,
    output logic       slot1_retire_o
);

    logic slot1_clean;
    logic slot1_store_ok;

    always_comb begin
        slot0_retire_o = commit_valid_i[0] &
                         (~commit_is_store_i[0] | store_ready_i);

        slot1_clean    = commit_valid_i[1] & ~commit_ex_i[1] &
                         ~commit_is_csr_i[1] & ~commit_is_fence_i[1];

        // Only one store can enter the store buffer per cycle.
        slot1_store_ok = ~commit_is_store_i[1] |
                         (~commit_is_store_i[0] & store_ready_i);

        slot1_retire_o = slot0_retire_o & slot1_clean & slot1_store_ok;
    end

endmodule

// File: rtl/gl_commit_ctrl.sv
// Commit sequencer for the graduation list. Inspects the two oldest GL
// slots each cycle and requests retirement of 0/1/2 instructions,
// serialises CSR and FENCE instructions and raises precise traps.
//   clk_i, rstn_i       : clock, asynchronous active-low reset
//   commit_*_i          : per-slot status of the two oldest GL entries
//   commit_gl_entry_i   : GL head index
//   exception_i         : oldest pending exception, at exception_index_i
//   interrupt_i         : enabled interrupt pending, cause interrupt_cause_i
//   store_ready_i       : store buffer accepts one store this cycle
//   sb_empty_i          : store buffer drained
//   csr_ack_i, csr_ex_i : CSR unit completion / fault
//   read_head_o         : retire request {slot1,slot0}
//   flush_commit_o      : one-cycle pipeline flush
//   csr_req_o           : CSR execute request, high while waiting for ack
//   trap_o, trap_*_o    : one-cycle trap pulse with cause/tval
//   instret_o           : retired instruction count
module gl_commit_ctrl
    import gl_commit_ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W = 64,
    parameter int unsigned CAUSE_W   = 64
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [1:0]           commit_valid_i,
    input  logic [1:0]           commit_ex_i,
    input  logic [1:0]           commit_is_store_i,
    input  logic [1:0]           commit_is_csr_i,
    input  logic [1:0]           commit_is_fence_i,
    input  gl_index_t            commit_gl_entry_i,
    input  exception_t           exception_i,
    input  gl_index_t            exception_index_i,
    input  logic                 interrupt_i,
    input  logic [CAUSE_W-1:0]   interrupt_cause_i,
    input  logic                 store_ready_i,
    input  logic                 sb_empty_i,
    input  logic                 csr_ack_i,
    input  logic                 csr_ex_i,
    output logic [1:0]           read_head_o,
    output logic                 flush_commit_o,
    output logic                 csr_req_o,
    output logic                 trap_o,
    output logic [CAUSE_W-1:0]   trap_cause_o,
    output logic [CAUSE_W-1:0]   trap_tval_o,
    output logic [INSTRET_W-1:0] instret_o
);

    commit_state_t        state_q, state_d;
    logic                 csr_req_q;
    logic                 flush_q;
    logic [INSTRET_W-1:0] instret_q;

    logic slot0_ok, slot1_ok;
    logic idle_active;
    logic ex_match;
    logic take_irq, take_ex, start_csr, start_fence, normal_commit;

    gl_retire_select u_retire_select (
        .commit_valid_i    (commit_valid_i),
        .commit_ex_i       (commit_ex_i),
        .commit_is_store_i (commit_is_store_i),
        .commit_is_csr_i   (commit_is_csr_i),
        .commit_is_fence_i (commit_is_fence_i),
        .store_ready_i     (store_ready_i),
        .slot0_retire_o    (slot0_ok),
        .slot1_retire_o    (slot1_ok)
    );

    // IDLE decode. The cycle after a flush is ignored so that flush and
    // trap can never pulse back to back, even if the GL is slow to empty.
    assign idle_active   = (state_q == IDLE) & commit_valid_i[0] & ~flush_q;
    assign ex_match      = commit_ex_i[0] & exception_i.valid &
                           (exception_index_i == commit_gl_entry_i);
    assign take_irq      = idle_active & interrupt_i;
    assign take_ex       = idle_active & ~interrupt_i & ex_match;
    assign start_csr     = idle_active & ~interrupt_i & ~ex_match &
                           commit_is_csr_i[0];
    assign start_fence   = idle_active & ~interrupt_i & ~ex_match &
                           ~commit_is_csr_i[0] & commit_is_fence_i[0];
    assign normal_commit = idle_active & ~interrupt_i & ~ex_match &
                           ~commit_is_csr_i[0] & ~commit_is_fence_i[0];

    // State register, CSR request and retire counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            csr_req_q <= 1'b0;
            flush_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            csr_req_q <= (state_d == CSR_WAIT);
            flush_q   <= flush_commit_o;
            instret_q <= instret_q + INSTRET_W'(popcount2(read_head_o));
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_csr) begin
                    state_d = CSR_WAIT;
                end else if (start_fence) begin
                    state_d = FENCE_DRAIN;
                end
            end
            CSR_WAIT: begin
                if (csr_ack_i) begin
                    state_d = IDLE;
                end
            end
            FENCE_DRAIN: begin
                if (sb_empty_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        read_head_o    = 2'b00;
        flush_commit_o = 1'b0;
        trap_o         = 1'b0;
        trap_cause_o   = '0;
        trap_tval_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (take_irq) begin
                    trap_o         = 1'b1;
                    trap_cause_o   = interrupt_cause_i;
                    flush_commit_o = 1'b1;
                end else if (take_ex) begin
                    trap_o         = 1'b1;
                    trap_cause_o   = CAUSE_W'(exception_i.cause);
                    trap_tval_o    = CAUSE_W'(exception_i.origin);
                    flush_commit_o = 1'b1;
                end else if (normal_commit) begin
                    read_head_o = {slot1_ok, slot0_ok};
                end
            end
            CSR_WAIT: begin
                if (csr_ack_i) begin
                    flush_commit_o = 1'b1;
                    if (csr_ex_i) begin
                        trap_o       = 1'b1;
                        trap_cause_o = CAUSE_W'(exception_i.cause);
                        trap_tval_o  = CAUSE_W'(exception_i.origin);
                    end else begin
                        read_head_o = 2'b01;
                    end
                end
            end
            FENCE_DRAIN: begin
                if (sb_empty_i) begin
                    read_head_o    = 2'b01;
                    flush_commit_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign csr_req_o = csr_req_q;
    assign instret_o = instret_q;

endmodule
